// File: rtl/serial_add_tree_if.sv
// rtl/serial_add_tree_if.sv - operand/sum handshake bundle for the bit-serial adder tree
interface serial_add_tree_if #(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int FULLW = 0
);
  localparam int OW = W + (FULLW != 0 ? $clog2(N) : 0);

  logic          in_valid;
  logic          in_ready;
  logic [N*W-1:0] operands;
  logic          out_valid;
  logic [OW-1:0] q;

  modport master (
    output in_valid,
    output operands,
    input  in_ready,
    input  out_valid,
    input  q
  );

  modport slave (
    input  in_valid,
    input  operands,
    output in_ready,
    output out_valid,
    output q
  );
endinterface

// File: rtl/serial_add_tree.sv
// rtl/serial_add_tree.sv - parametrised bit-serial adder tree with framed serialiser/deserialiser
module serial_add_tree #(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int FULLW = 0
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_tree_if.slave  bus
);
  localparam int L  = $clog2(N);
  localparam int OW = W + (FULLW != 0 ? L : 0);
  localparam int F  = OW;
  localparam int CW = $clog2(F);

  logic          busy;
  logic [CW-1:0] cnt;
  logic          last_bit;
  logic          accept;
  logic [L:0]    tap;
  logic [L:1]    lt;

  logic [OW-1:0] sr [N];

  logic [2*N-1:1] t;
  logic [N-1:1]   node;
  logic [N-1:1]   cy;
  logic [N-1:1]   nxt_s;
  logic [N-1:1]   nxt_c;

  logic [OW-2:0] dsr;
  logic [OW-1:0] q_r;
  logic          ov_r;

  assign last_bit     = busy && (cnt == CW'(F - 1));
  assign bus.in_ready = !busy || last_bit;
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.q        = q_r;
  assign bus.out_valid = ov_r;

  // Operand shift registers: load zero-extended on accept, shift LSB-first while framing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < N; j++) sr[j] <= '0;
    end else if (accept) begin
      for (int j = 0; j < N; j++) sr[j] <= OW'(bus.operands[j*W +: W]);
    end else if (busy) begin
      for (int j = 0; j < N; j++) sr[j] <= sr[j] >> 1;
    end
  end

  // Frame control: bit counter, frame-start token taps and frame-end token taps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      tap  <= '0;
      lt   <= '0;
    end else begin
      if (accept) begin
        busy <= 1'b1;
        cnt  <= '0;
      end else if (last_bit) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else if (busy) begin
        cnt <= cnt + 1'b1;
      end
      tap[0] <= accept;
      for (int k = 1; k <= L; k++) tap[k] <= tap[k-1];
      lt[1] <= last_bit;
      for (int k = 2; k <= L; k++) lt[k] <= lt[k-1];
    end
  end

  // Heap-ordered tree: leaves at t[N..2N-1], adder i reads t[2i], t[2i+1], root is t[1]
  for (genvar j = 0; j < N; j++) begin : g_leaf
    assign t[N+j] = sr[j][0];
  end

  for (genvar i = 1; i < N; i++) begin : g_node
    localparam int K = L - ($clog2(i + 1) - 1);
    logic a, b, cin;
    assign t[i]     = node[i];
    assign a        = t[2*i];
    assign b        = t[2*i+1];
    assign cin      = tap[K-1] ? 1'b0 : cy[i];
    assign nxt_s[i] = a ^ b ^ cin;
    assign nxt_c[i] = (a & b) | (a & cin) | (b & cin);
  end

  // Serial adder state: one registered sum bit and carry per tree node
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      node <= '0;
      cy   <= '0;
    end else begin
      node <= nxt_s;
      cy   <= nxt_c;
    end
  end

  // Deserialiser: MSB-in right shift, publish the full word when the frame's last bit arrives
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dsr  <= '0;
      q_r  <= '0;
      ov_r <= 1'b0;
    end else begin
      dsr  <= (OW-1)'({t[1], dsr} >> 1);
      ov_r <= lt[L];
      if (lt[L]) q_r <= {t[1], dsr};
    end
  end
endmodule

// File: doc/serial_add_tree.md
# serial_add_tree

Parametrised bit-serial adder tree: accepts N unsigned W-bit operands in parallel, serialises them LSB-first, reduces them through a log2(N)-level tree of 1-bit serial adders, and deserialises the sum. It is the generalised successor of the fixed 4-operand, 8-bit serial adder. It adds a valid/ready input handshake, back-to-back frame pipelining and optional full-precision (non-wrapping) sums. It sits between parallel datapath registers and any consumer that tolerates multi-cycle latency in exchange for minimal adder area.

## Interface
- W, 8: operand width in bits; W >= 2.
- N, 4: operand count; a power of two, N >= 2; L = log2(N) tree levels.
- FULLW, 0: 0 gives sum width OW = W (modulo 2^W); 1 gives OW = W + L (exact sum).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operand set on `operands` is valid.
- in_ready  out  1  block accepts an operand set this cycle.
- operands  in  N*W  packed operands; operand j is bits [j*W +: W].
- out_valid  out  1  one-cycle pulse: `q` has just been updated with a new sum.
- q  out  OW  last completed sum; held until the next completion.

## Operation
- Frame length F = OW bit-cycles. Each accepted operand set occupies exactly one frame.
- Accept on a rising edge where in_valid && in_ready. N shift registers load the operands, zero-extended to OW bits.
- Serialisation: bit i of every operand drives the tree during the cycle after edge E0+i, for i = 0..F-1.
  - E0 is the accept edge.
  - Zero-extension supplies the carry-growth bits when FULLW=1.
- Frame control: a bit counter 0..F-1 plus a frame-start token.
  - The token is delayed one cycle per tree level, giving L+1 taps. This generalises the fixed ring counter.
- Tree level k (1..L) has N/2^k serial adders. Each adder has a registered sum bit and a registered carry.
  - Carry is forced to 0 on the bit-0 cycle of that level, using tap k-1.
  - The level output therefore lags level k-1 by one cycle.
- Final carry out of level L beyond bit F-1 is discarded.
  - FULLW=0: sum is modulo 2^W.
  - FULLW=1: sum is exact.
- Deserialiser: an OW-bit shift register fills MSB-in, right-shifting.
  - On the edge that shifts in bit F-1, q <= {bit, sr[OW-1:1]} and out_valid = 1 for that one cycle.
- in_ready = 1 when the serialiser is idle, or during its bit F-1 cycle. This allows back-to-back frames with no bubble.
- Tree and deserialiser frames overlap: up to ceil((L+1)/F)+1 frames can be in flight. Per-level carry clear keeps them independent.
- No output backpressure. A consumer must capture q on out_valid or before the next out_valid.

## Timing
- Reset (rst low, asynchronous) clears the following:
  - q = 0, out_valid = 0;
  - all shift registers, carries, counters and token taps = 0;
  - in_ready = 1 from the first edge after rst deasserts.
- Latency: accept at edge E0 gives q valid and out_valid = 1 after edge E0+F+L.
  - W=8, N=4, FULLW=0: 10 cycles.
  - W=8, N=4, FULLW=1: 12 cycles.
- Throughput: one operand set per F cycles with in_valid held high.
  - Back-to-back completions are exactly F cycles apart.
- in_valid low at frame end: the serialiser goes idle and in_ready stays 1.
  - In-flight tree and deserialiser work still completes.
- in_valid high while in_ready is 0: no accept, operands ignored, no state change.
- Reset mid-frame aborts all in-flight frames: no out_valid is produced for them and q reads 0.
- A new frame entering level k in the same cycle as the previous frame's last bit: the carry clear applies only to the new frame's bit 0.

## Test plan
- Reset, then accept {1,2,3,4} (W=8, N=4, FULLW=0) -> out_valid exactly 10 cycles after accept, q = 8'd10; in_ready returns 1 on the accept frame's bit-7 cycle.
- Accept {255,255,255,255}: FULLW=0 gives q = 8'hFC; FULLW=1 gives q = 10'd1020 at latency 12.
- Three back-to-back sets {1,1,1,1}, {0x80,0x80,0,0}, {0xFF,1,0,0} with in_valid held -> out_valid every 8 cycles; q = 4, 0x00, 0x00 (FULLW=0), with no carry leakage between frames.
- N=8, W=4, FULLW=1, all operands 15 -> q = 7'd120 after F+L = 7+3 = 10 cycles.
- Assert rst low mid-frame (cycle 5 after accept) -> out_valid never pulses for that frame, q = 0; the next accepted {5,6,7,8} gives q = 26.
- Random operands, random in_valid gaps, W/N/FULLW sweep -> every q equals the reference sum (mod 2^OW), in order; out_valid count equals accept count.
